// File: rtl/alu_drv_pkg.sv
// rtl/alu_drv_pkg.sv - shared types, op encodings and expected-result model for the ALU command driver
package alu_drv_pkg;

  typedef enum logic [1:0] {
    OP_NULL   = 2'b00,
    OP_ANDADD = 2'b01,
    OP_SHL    = 2'b10,
    OP_SHR    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [2:0] tag;
  } cmd_t;

  typedef struct packed {
    logic       err;
    logic [4:0] data;
  } result_t;

  function automatic result_t expected_result(input cmd_t cmd);
    result_t r;
    r.err  = 1'b0;
    r.data = 5'h00;
    case (cmd.op)
      OP_NULL:   r.err  = 1'b1;
      OP_ANDADD: r.data = {1'b0, cmd.a & cmd.b} + {1'b0, cmd.c};
      OP_SHL:    r.data = {1'b0, cmd.a} << 1;
      OP_SHR:    r.data = {1'b0, cmd.a} >> 1;
      default:   r.err  = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_drv_fifo.sv
// rtl/alu_drv_fifo.sv - synchronous command FIFO; head entry is read combinationally
module alu_drv_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - issues queued commands to the registered ALU and returns tagged results
// Define ALU_DRV_SELFCHECK_EN to build the sticky result self-check behind chk_fail.
module alu_cmd_driver
  import alu_drv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_c,
  input  logic [2:0] cmd_tag,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_c,
  output logic [1:0] alu_m,
  input  logic [4:0] alu_out,
  input  logic       alu_err,
  input  logic       alu_cay,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_data,
  output logic       rsp_err,
  output logic       rsp_carry,
  output logic [2:0] rsp_tag,
  output logic       busy,
  output logic       chk_fail
);

  localparam int CNT_W  = $clog2(LAT + 1) + 1;
  localparam int FCNT_W = $clog2(DEPTH) + 1;

  cmd_t              push_cmd, head_cmd;
  logic              fifo_full, fifo_empty, load, capture;
  logic [FCNT_W-1:0] fifo_count;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_c_q, alu_c_d;
  logic [1:0]        alu_m_q, alu_m_d;
  logic [2:0]        cur_tag_q, cur_tag_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_carry_q, rsp_carry_d;
  logic [4:0]        rsp_data_q, rsp_data_d;
  logic [2:0]        rsp_tag_q, rsp_tag_d;

  assign push_cmd  = '{op: op_e'(cmd_op), a: cmd_a, b: cmd_b, c: cmd_c, tag: cmd_tag};
  assign cmd_ready = rst_n & ~fifo_full;
  assign capture   = (state_q == ISSUE) && (cnt_q == CNT_W'(LAT));

  alu_drv_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid & cmd_ready),
    .push_data (push_cmd),
    .pop       (load),
    .head_data (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_c_d     = alu_c_q;
    alu_m_d     = alu_m_q;
    cur_tag_d   = cur_tag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_carry_d = rsp_carry_q;
    rsp_tag_d   = rsp_tag_q;
    load        = 1'b0;
    case (state_q)
      IDLE: load = ~fifo_empty;
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (capture) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_out;
          rsp_err_d   = alu_err;
          // Shift modes leave the ALU carry stale, so only and-add reports it.
          rsp_carry_d = (alu_m_q == OP_ANDADD) & alu_cay;
          rsp_tag_d   = cur_tag_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          load        = ~fifo_empty;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      alu_a_d   = head_cmd.a;
      alu_b_d   = head_cmd.b;
      alu_c_d   = head_cmd.c;
      alu_m_d   = head_cmd.op;
      cur_tag_d = head_cmd.tag;
      cnt_d     = '0;
      state_d   = ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_c_q     <= '0;
      alu_m_q     <= '0;
      cur_tag_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_c_q     <= alu_c_d;
      alu_m_q     <= alu_m_d;
      cur_tag_q   <= cur_tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

`ifdef ALU_DRV_SELFCHECK_EN
  cmd_t    issued_cmd;
  result_t exp_res;
  logic    chk_fail_q, chk_fail_d;

  always_comb begin
    issued_cmd = '{op: op_e'(alu_m_q), a: alu_a_q, b: alu_b_q, c: alu_c_q, tag: cur_tag_q};
    exp_res    = expected_result(issued_cmd);
    chk_fail_d = chk_fail_q;
    if (capture && ((exp_res.data != alu_out) || (exp_res.err != alu_err))) chk_fail_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) chk_fail_q <= 1'b0;
    else        chk_fail_q <= chk_fail_d;
  end

  assign chk_fail = chk_fail_q;
`else
  assign chk_fail = 1'b0;
`endif

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_c     = alu_c_q;
  assign alu_m     = alu_m_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_tag   = rsp_tag_q;
  assign busy      = (fifo_count != '0) || (state_q != IDLE);

endmodule
